// File: rtl/clock_gate_pkg.sv
// Shared definitions for the clock gate sequencer.
//   - 3-bit state encodings for the sequencing FSM
//   - width helpers for the edge, hold and timeout counters
package clock_gate_pkg;

  typedef logic [2:0] cg_state_t;

  localparam cg_state_t ST_OFF   = 3'd0;
  localparam cg_state_t ST_WAKE  = 3'd1;
  localparam cg_state_t ST_ON    = 3'd2;
  localparam cg_state_t ST_HOLD  = 3'd3;
  localparam cg_state_t ST_FAULT = 3'd4;

  // Bits needed to hold 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int edge_cnt_w(input int wake_edges);
    return cnt_w(wake_edges);
  endfunction

  function automatic int hold_cnt_w(input int hold_cycles);
    return cnt_w(hold_cycles);
  endfunction

  function automatic int to_cnt_w(input int timeout);
    return cnt_w(timeout);
  endfunction

endpackage

// File: rtl/clock_edge_sync.sv
// Brings an asynchronous clock-as-data signal into the `clock` domain and
// flags its rising edges.
//   clock  : always-on sampling clock
//   reset  : async active-low reset
//   sig_in : asynchronous input (gated target clock)
//   rise   : one-cycle pulse per synchronized rising edge (2-3 cycle latency)
module clock_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  logic sync1, sync2, sync3;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // sync3 is only a delayed copy of the settled sync2 for edge detect.
  assign rise = sync2 & ~sync3;

endmodule

// File: rtl/clock_gate_seq.sv
// Sequences the ICG enable of one gated clock domain for NREQ requesters.
// The gated clock is confirmed running (WAKE_EDGES synchronized rising edges)
// before any grant; after the last request drops the clock is held on for
// HOLD_CYCLES idle cycles. A wake that never sees the clock start ends in
// FAULT until err_clr.
//   clock       : always-on clock
//   reset       : async active-low reset
//   req         : per-requester level request
//   ack         : per-requester grant (req gated by ON/HOLD)
//   tgt_clk_sig : gated target clock as data, asynchronous
//   clk_en      : registered ICG enable
//   busy        : WAKE or HOLD
//   timeout_err : FAULT
//   err_clr     : pulse clearing FAULT
module clock_gate_seq
  import clock_gate_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int WAKE_EDGES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  input  logic            tgt_clk_sig,
  output logic            clk_en,
  output logic            busy,
  output logic            timeout_err,
  input  logic            err_clr
);

  localparam int EW = edge_cnt_w(WAKE_EDGES);
  localparam int HW = hold_cnt_w(HOLD_CYCLES);
  localparam int TW = to_cnt_w(TIMEOUT);

  localparam logic [EW-1:0] EDGE_LAST = EW'(WAKE_EDGES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  cg_state_t     state, state_nxt;
  logic [EW-1:0] edge_cnt;
  logic [HW-1:0] hold_cnt;
  logic [TW-1:0] to_cnt;
  logic          tgt_rise;
  logic          any_req;

  assign any_req = |req;

  clock_edge_sync u_sync (
    .clock  (clock),
    .reset  (reset),
    .sig_in (tgt_clk_sig),
    .rise   (tgt_rise)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:   if (any_req) state_nxt = ST_WAKE;
      // Final edge wins over timeout when both land in the same cycle.
      ST_WAKE:  if (tgt_rise && edge_cnt == EDGE_LAST) state_nxt = ST_ON;
                else if (to_cnt == TO_LAST)            state_nxt = ST_FAULT;
      ST_ON:    if (!any_req) state_nxt = ST_HOLD;
      ST_HOLD:  if (any_req)             state_nxt = ST_ON;
                else if (hold_cnt == '0) state_nxt = ST_OFF;
      ST_FAULT: if (err_clr) state_nxt = ST_OFF;
      default:  state_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_OFF;
      clk_en   <= 1'b0;
      edge_cnt <= '0;
      hold_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      state  <= state_nxt;
      // Enable follows the next state so it changes together with the state.
      clk_en <= (state_nxt == ST_WAKE) || (state_nxt == ST_ON) ||
                (state_nxt == ST_HOLD);
      case (state)
        // WAKE is only entered from OFF, so clearing here restarts each wake.
        ST_OFF: begin
          edge_cnt <= '0;
          to_cnt   <= '0;
        end
        ST_WAKE: begin
          if (to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;
          if (tgt_rise && edge_cnt != EDGE_LAST) edge_cnt <= edge_cnt + 1'b1;
        end
        // Reloaded every ON cycle so HOLD always starts from a full window.
        ST_ON:   hold_cnt <= HOLD_LOAD;
        ST_HOLD: if (!any_req && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign ack         = (state == ST_ON || state == ST_HOLD) ? req : '0;
  assign busy        = (state == ST_WAKE) || (state == ST_HOLD);
  assign timeout_err = (state == ST_FAULT);

endmodule

// File: tb/tb_clock_gate_seq.sv
// Scoreboard bench for clock_gate_seq. Two instances run side by side on the
// same requests: one with default parameters, one with WAKE_EDGES=1,
// TIMEOUT=8, HOLD_CYCLES=4 for the edge-vs-timeout tie. A behavioural model
// predicts outputs per cycle into a queue; a negedge monitor pops and compares.
module tb_clock_gate_seq;

  localparam int NREQ = 4;
  localparam int WE1 = 4, HC1 = 16, TO1 = 64;
  localparam int WE2 = 1, HC2 = 4,  TO2 = 8;
  localparam int M_OFF = 0, M_WAKE = 1, M_ON = 2, M_HOLD = 3, M_FAULT = 4;

  typedef struct { int mode; int age; int rises; int idle; } mdl_t;
  typedef struct packed { logic [NREQ-1:0] ack; logic en; logic busy; logic err; } obs_t;
  typedef struct { obs_t o1; obs_t o2; } exp_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic            err_clr = 1'b0;
  logic            tgt1 = 1'b0, tgt2 = 1'b0;
  logic [NREQ-1:0] ack1, ack2;
  logic            clk_en1, clk_en2, busy1, busy2, terr1, terr2;

  always #5 clock = ~clock;

  clock_gate_seq #(.NREQ(NREQ), .WAKE_EDGES(WE1), .HOLD_CYCLES(HC1), .TIMEOUT(TO1)) u_dut (
    .clock(clock), .reset(reset), .req(req), .ack(ack1), .tgt_clk_sig(tgt1),
    .clk_en(clk_en1), .busy(busy1), .timeout_err(terr1), .err_clr(err_clr));

  clock_gate_seq #(.NREQ(NREQ), .WAKE_EDGES(WE2), .HOLD_CYCLES(HC2), .TIMEOUT(TO2)) u_dut2 (
    .clock(clock), .reset(reset), .req(req), .ack(ack2), .tgt_clk_sig(tgt2),
    .clk_en(clk_en2), .busy(busy2), .timeout_err(terr2), .err_clr(err_clr));

  mdl_t md1 = '{M_OFF, 0, 0, 0};
  mdl_t md2 = '{M_OFF, 0, 0, 0};
  bit   hist1[$], hist2[$];   // target samples seen at each clock edge
  exp_t exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   tmode1 = 0, tmode2 = 0, tcnt1 = 0, tcnt2 = 0;

  // Behavioural view: rises accumulate during a wake; WAKE_EDGES of them turn
  // the clock on, TIMEOUT cycles without them is a fault; HOLD_CYCLES idle
  // cycles after the last request turn it off.
  function automatic mdl_t step(mdl_t m, logic [NREQ-1:0] r, logic ec, bit rise,
                                int we, int hc, int to);
    case (m.mode)
      M_OFF:   if (|r) begin m.mode = M_WAKE; m.age = 0; m.rises = 0; end
      M_WAKE: begin
        m.rises += int'(rise);
        m.age++;
        if (m.rises >= we)    m.mode = M_ON;
        else if (m.age >= to) m.mode = M_FAULT;
      end
      M_ON:    if (r == '0) begin m.mode = M_HOLD; m.idle = 0; end
      M_HOLD: begin
        if (|r) m.mode = M_ON;
        else begin
          m.idle++;
          if (m.idle >= hc) m.mode = M_OFF;
        end
      end
      default: if (ec) m.mode = M_OFF;
    endcase
    return m;
  endfunction

  // A rise seen at edge m comes from samples taken at edges m-2 (high) and m-3 (low).
  function automatic bit rise_of(bit h[$]);
    if (h.size() < 3) return 1'b0;
    return h[h.size()-2] & ~h[h.size()-3];
  endfunction

  function automatic obs_t expect_of(mdl_t m, logic [NREQ-1:0] r);
    obs_t o;
    o.en   = (m.mode == M_WAKE) || (m.mode == M_ON) || (m.mode == M_HOLD);
    o.busy = (m.mode == M_WAKE) || (m.mode == M_HOLD);
    o.err  = (m.mode == M_FAULT);
    o.ack  = (m.mode == M_ON || m.mode == M_HOLD) ? r : '0;
    return o;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  task automatic cmp_obs(string name, obs_t got, obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got ack=%b en=%b busy=%b err=%b, expected ack=%b en=%b busy=%b err=%b",
               name, $time, got.ack, got.en, got.busy, got.err,
               want.ack, want.en, want.busy, want.err);
    end
  endtask

  // Target clock generators: 0 stuck low, 1 clock/8, 2 random (>=2 cycles per level), 3 manual.
  task automatic tgt_gen(inout logic t, inout int cnt, input int mode);
    case (mode)
      0: t = 1'b0;
      1: if (cnt <= 0) begin t = ~t; cnt = 3; end else cnt--;
      2: if (cnt <= 0) begin t = ~t; cnt = $urandom_range(1, 5); end else cnt--;
      default: ;
    endcase
  endtask

  // Called just after a posedge: push this cycle's expectation, then advance
  // the model across the next edge.
  task automatic tick();
    exp_t e;
    tgt_gen(tgt1, tcnt1, tmode1);
    tgt_gen(tgt2, tcnt2, tmode2);
    e.o1 = expect_of(md1, req);
    e.o2 = expect_of(md2, req);
    exp_q.push_back(e);
    @(posedge clock);
    if (reset) begin
      bit r1, r2;
      r1 = rise_of(hist1);
      r2 = rise_of(hist2);
      md1 = step(md1, req, err_clr, r1, WE1, HC1, TO1);
      md2 = step(md2, req, err_clr, r2, WE2, HC2, TO2);
      hist1.push_back(tgt1);
      hist2.push_back(tgt2);
    end else begin
      hist1.push_back(1'b0);
      hist2.push_back(1'b0);
    end
    while (hist1.size() > 4) void'(hist1.pop_front());
    while (hist2.size() > 4) void'(hist2.pop_front());
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    md1 = '{M_OFF, 0, 0, 0};
    md2 = '{M_OFF, 0, 0, 0};
    hist1.delete();
    hist2.delete();
    #1;
    chk("rst_async_en1", 32'(clk_en1), 0);
    chk("rst_async_en2", 32'(clk_en2), 0);
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp_obs("dut1_out", {ack1, clk_en1, busy1, terr1}, e.o1);
      cmp_obs("dut2_out", {ack2, clk_en2, busy2, terr2}, e.o2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hb;
    @(posedge clock);
    #1;
    // Reset held: everything quiet.
    repeat (3) tick();
    chk("rst_clk_en", 32'(clk_en1), 0);
    chk("rst_ack", 32'(ack1), 0);
    chk("rst_err", 32'(terr1), 0);
    reset = 1'b1;
    repeat (4) tick();

    // 1: wake with target at clock/8.
    tmode1 = 1; tmode2 = 1;
    req = 4'b0001;
    tick();
    chk("t1_clk_en", 32'(clk_en1), 1);
    n = 0;
    while (ack1[0] !== 1'b1 && n < 60) begin tick(); n++; end
    chk("t1_ack_seen", 32'(ack1[0]), 1);
    chk("t1_latency_ok", 32'(n >= 20 && n <= 40), 1);

    // 2: hold window length after dropping all requests.
    req = '0;
    tick();
    hb = 0; n = 0;
    while (busy1 === 1'b1 && n < 40) begin hb++; tick(); n++; end
    chk("t2_hold_len", 32'(hb), 16);
    chk("t2_off_en", 32'(clk_en1), 0);

    // 3: request returning mid-hold goes straight to ON.
    req = 4'b0001;
    tick();
    n = 0;
    while (ack1[0] !== 1'b1 && n < 60) begin tick(); n++; end
    chk("t3_on", 32'(ack1[0]), 1);
    req = '0;
    tick();
    repeat (10) tick();
    req = 4'b0100;
    tick();
    chk("t3_ack2", 32'(ack1[2]), 1);
    chk("t3_not_busy", 32'(busy1), 0);
    chk("t3_en", 32'(clk_en1), 1);

    // 4: stuck target clock -> FAULT after TIMEOUT wake cycles, then clear.
    req = '0;
    tmode1 = 0; tmode2 = 0;
    repeat (24) tick();
    req = 4'b0010;
    tick();
    n = 0;
    while (terr1 !== 1'b1 && n < 100) begin tick(); n++; end
    chk("t4_wake_cycles", 32'(n), 64);
    chk("t4_fault_en", 32'(clk_en1), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_off_err", 32'(terr1), 0);
    chk("t4_off_en", 32'(clk_en1), 0);
    tick();
    chk("t4_rewake", 32'(busy1), 1);

    // 5: reset in the middle of a wake, after two edges.
    tmode1 = 1; tcnt1 = 0;
    n = 0;
    while (!(md1.mode == M_WAKE && md1.rises == 2) && n < 60) begin tick(); n++; end
    chk("t5_mid_wake", 32'(md1.rises), 2);
    chk("t5_pre_en", 32'(clk_en1), 1);
    do_reset();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    n = 0;
    while (ack1[1] !== 1'b1 && n < 60) begin tick(); n++; end
    chk("t5_rewake_on", 32'(ack1[1]), 1);

    // 6: on instance 2, the only edge lands on the last timeout cycle.
    req = '0;
    repeat (30) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    tmode2 = 3; tgt2 = 1'b0;
    repeat (5) tick();
    chk("t6_pre_off", 32'(clk_en2), 0);
    req = 4'b0001;
    repeat (6) tick();
    tgt2 = 1'b1;
    repeat (3) tick();
    chk("t6_on", 32'(ack2[0]), 1);
    chk("t6_no_fault", 32'(terr2), 0);

    // 7: random traffic.
    tmode1 = 2; tmode2 = 2;
    repeat (800) begin
      if ($urandom_range(0, 7) == 0) req = NREQ'($urandom);
      err_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) == 0) begin
        tmode1 = $urandom_range(0, 2);
        tmode2 = $urandom_range(0, 2);
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        tick();
        reset = 1'b1;
      end
      tick();
    end

    req = '0;
    err_clr = 1'b0;
    repeat (5) tick();
    @(negedge clock);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
